// File: rtl/fir_mc_serial_if.sv
// Handshake and coefficient-bus bundle for the multi-channel serial FIR.
// The master drives samples and coefficient writes; the slave returns results.
interface fir_mc_serial_if #(
  parameter int WIDTH_DATA  = 8,
  parameter int WIDTH_COEF  = 8,
  parameter int LOG2_N_TAPS = 4,
  parameter int LOG2_N_CH   = 1,
  parameter int WIDTH_OUT   = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LOG2_N_CH-1:0]          in_ch;
  logic signed [WIDTH_DATA-1:0]  din;
  logic                          coef_we;
  logic [LOG2_N_TAPS-1:0]        coef_addr;
  logic signed [WIDTH_COEF-1:0]  coef_data;
  logic                          out_valid;
  logic [LOG2_N_CH-1:0]          out_ch;
  logic signed [WIDTH_OUT-1:0]   dout;

  modport master (
    output in_valid, in_ch, din, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_ch, dout
  );

  modport slave (
    input  in_valid, in_ch, din, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_ch, dout
  );
endinterface

// File: rtl/fir_mc_serial.sv
// Time-interleaved multi-channel FIR sharing one MAC, one tap per cycle,
// with a writable shared coefficient bank and rounded, saturated output.
module fir_mc_serial #(
  parameter int WIDTH_DATA  = 8,
  parameter int WIDTH_COEF  = 8,
  parameter int N_TAPS      = 16,
  parameter int LOG2_N_TAPS = 4,
  parameter int N_CH        = 2,
  parameter int LOG2_N_CH   = 1,
  parameter int WIDTH_OUT   = 8,
  parameter int SHIFT       = 0
) (
  input  logic           clk,
  input  logic           rst,
  fir_mc_serial_if.slave bus
);
  localparam int WIDTH_PROD = WIDTH_DATA + WIDTH_COEF;
  localparam int WIDTH_ACC  = WIDTH_PROD + LOG2_N_TAPS;
  localparam logic [LOG2_N_TAPS-1:0] TAP_ONE = LOG2_N_TAPS'(1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state_reg;
  logic signed [WIDTH_DATA-1:0]  hist_reg [N_CH][N_TAPS];
  logic [LOG2_N_TAPS-1:0]        ptr_reg  [N_CH];
  logic signed [WIDTH_COEF-1:0]  coef_reg [N_TAPS];
  logic [LOG2_N_CH-1:0]          ch_reg;
  logic [LOG2_N_TAPS-1:0]        k_reg;
  logic signed [WIDTH_ACC-1:0]   acc_reg;
  logic                          in_ready_reg;
  logic                          out_valid_reg;
  logic [LOG2_N_CH-1:0]          out_ch_reg;
  logic signed [WIDTH_OUT-1:0]   dout_reg;

  logic [LOG2_N_TAPS-1:0]        tap_idx;
  logic signed [WIDTH_PROD-1:0]  prod;
  logic signed [WIDTH_ACC-1:0]   prod_ext;
  logic signed [WIDTH_ACC:0]     acc_ext;
  logic signed [WIDTH_ACC:0]     rnd;
  logic signed [WIDTH_OUT-1:0]   sat;
  logic                          fits;

  // Newest sample sits at ptr; tap k reaches k samples back, wrapping naturally.
  assign tap_idx  = ptr_reg[ch_reg] - k_reg;
  assign prod     = coef_reg[k_reg] * hist_reg[ch_reg][tap_idx];
  assign prod_ext = {{LOG2_N_TAPS{prod[WIDTH_PROD-1]}}, prod};
  assign acc_ext  = {acc_reg[WIDTH_ACC-1], acc_reg};

  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd = acc_ext;
    end else begin : g_round
      localparam logic signed [WIDTH_ACC:0] BIAS = {{WIDTH_ACC{1'b0}}, 1'b1} << (SHIFT - 1);
      assign rnd = (acc_ext + BIAS) >>> SHIFT;
    end
  endgenerate

  // In range when every bit above the output sign bit equals it.
  assign fits = (&rnd[WIDTH_ACC:WIDTH_OUT-1]) | ~(|rnd[WIDTH_ACC:WIDTH_OUT-1]);
  assign sat  = fits ? rnd[WIDTH_OUT-1:0]
              : (rnd[WIDTH_ACC] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                : {1'b0, {(WIDTH_OUT-1){1'b1}}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      dout_reg      <= '0;
      ch_reg        <= '0;
      k_reg         <= '0;
      acc_reg       <= '0;
      for (int c = 0; c < N_CH; c++) begin
        ptr_reg[c] <= '0;
        for (int t = 0; t < N_TAPS; t++) hist_reg[c][t] <= '0;
      end
      for (int t = 0; t < N_TAPS; t++) coef_reg[t] <= WIDTH_COEF'(1);
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Coefficient write lands on the same edge as a handshake, so MAC sees it.
          if (bus.coef_we && in_ready_reg) coef_reg[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid && in_ready_reg) begin
            hist_reg[bus.in_ch][ptr_reg[bus.in_ch]] <= bus.din;
            ch_reg       <= bus.in_ch;
            acc_reg      <= '0;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          k_reg   <= k_reg + TAP_ONE;
          if (&k_reg) state_reg <= OUT;
        end
        OUT: begin
          dout_reg        <= sat;
          out_ch_reg      <= ch_reg;
          out_valid_reg   <= 1'b1;
          ptr_reg[ch_reg] <= ptr_reg[ch_reg] + TAP_ONE;
          in_ready_reg    <= 1'b1;
          state_reg       <= IDLE;
        end
        default: begin
          in_ready_reg <= 1'b1;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.dout      = dout_reg;
endmodule
